// File: rtl/data_sniffer_if.sv
// Byte-stream bus between a source/sink pair and the digit sniffer.
// The master side drives input bytes and observes the forwarded byte stream;
// the slave side (the sniffer) consumes bytes and strobes forwarded output.
interface data_sniffer_if;
    logic       enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       write;

    modport master (
        output enable,
        output data_in,
        input  data_out,
        input  write
    );

    modport slave (
        input  enable,
        input  data_in,
        output data_out,
        output write
    );
endinterface

// File: rtl/data_sniffer.sv
// Digit-run sniffer: scans an ASCII byte stream, buffers each run of decimal
// digits tentatively in a circular FIFO, and commits it (followed by SEP) only
// when the run is terminated with an acceptable length. Committed bytes are
// drained one per cycle through a registered output.
module data_sniffer #(
    parameter int         MIN_LEN = 3,
    parameter int         MAX_LEN = 16,
    parameter int         DEPTH   = 32,
    parameter logic [7:0] SEP     = 8'h20
) (
    input  logic          clk,
    input  logic          rst_n,
    data_sniffer_if.slave bus
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int RLW = $clog2(MAX_LEN + 1);

    // Byte storage; left unreset so it maps onto block RAM.
    logic [7:0] mem [DEPTH];

    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]  tw_ptr_reg, tw_ptr_next;
    logic [RLW-1:0] run_len_reg, run_len_next;
    logic           drop_reg, drop_next;
    logic [7:0]     data_out_reg, data_out_next;
    logic           write_reg, write_next;

    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [7:0]     mem_wdata;

    logic           is_digit;
    logic           fifo_full;

    assign is_digit  = (bus.data_in >= 8'h30) && (bus.data_in <= 8'h39);
    // Tentative data may never overwrite committed bytes that are still unread.
    assign fifo_full = ((tw_ptr_reg - rd_ptr_reg) == PW'(DEPTH));

    // Input side: extend, drop, commit or roll back the current digit run.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        tw_ptr_next  = tw_ptr_reg;
        run_len_next = run_len_reg;
        drop_next    = drop_reg;
        mem_we       = 1'b0;
        mem_waddr    = tw_ptr_reg[AW-1:0];
        mem_wdata    = bus.data_in;

        if (bus.enable) begin
            if (is_digit) begin
                if (!drop_reg && (run_len_reg < RLW'(MAX_LEN)) && !fifo_full) begin
                    mem_we       = 1'b1;
                    tw_ptr_next  = tw_ptr_reg + PW'(1);
                    run_len_next = run_len_reg + RLW'(1);
                end else begin
                    // Over-long run or no room: the whole run is abandoned.
                    drop_next = 1'b1;
                end
            end else begin
                if ((run_len_reg >= RLW'(MIN_LEN)) && !drop_reg && !fifo_full) begin
                    mem_we      = 1'b1;
                    mem_wdata   = SEP;
                    tw_ptr_next = tw_ptr_reg + PW'(1);
                    wr_ptr_next = tw_ptr_reg + PW'(1);
                end else begin
                    tw_ptr_next = wr_ptr_reg;
                end
                run_len_next = '0;
                drop_next    = 1'b0;
            end
        end
    end

    // Output side: drain one committed byte per cycle while any are pending.
    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        data_out_next = data_out_reg;
        write_next    = 1'b0;
        if (rd_ptr_reg != wr_ptr_reg) begin
            data_out_next = mem[rd_ptr_reg[AW-1:0]];
            write_next    = 1'b1;
            rd_ptr_next   = rd_ptr_reg + PW'(1);
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // State and output registers; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            tw_ptr_reg   <= '0;
            run_len_reg  <= '0;
            drop_reg     <= 1'b0;
            data_out_reg <= 8'h00;
            write_reg    <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            tw_ptr_reg   <= tw_ptr_next;
            run_len_reg  <= run_len_next;
            drop_reg     <= drop_next;
            data_out_reg <= data_out_next;
            write_reg    <= write_next;
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.write    = write_reg;
endmodule

// File: tb/tb_data_sniffer.sv
// Directed bench for the digit-run sniffer: byte streams in, forwarded
// byte streams (and cycle-exact strobes) compared against hand-derived text.
module tb_data_sniffer;
    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [7:0] out_q [$];

    data_sniffer_if bus ();

    data_sniffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Collect every forwarded byte, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.write) out_q.push_back(bus.data_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_stream(input string tag, input string exp);
        string got = "";
        foreach (out_q[i]) got = $sformatf("%s%c", got, out_q[i]);
        total_cnt++;
        assert (got == exp) pass_cnt++;
        else $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, got, exp);
        out_q.delete();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.data_in = s[i];
            bus.enable  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.enable = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.enable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        string t6;
        t6 = "123 ";
        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_write", {31'b0, bus.write}, 32'd0);
        chk("reset_data", {24'b0, bus.data_out}, 32'h00);
        rst_n = 1'b1;
        idle(2);

        // Mixed stream with four valid runs and an unterminated tail.
        send_str("a729 8992 561ff729892561gsdf");
        idle(40);
        chk_stream("t1_stream", "729 8992 561 729892561 ");

        // Runs shorter than the minimum.
        send_str("12 7x");
        idle(10);
        chk_stream("t2_short", "");

        // 17 digits are dropped, then a normal run goes through.
        send_str("12345678901234567 ");
        idle(10);
        chk_stream("t3_too_long", "");
        send_str("345;");
        idle(10);
        chk_stream("t3_after_drop", "345 ");

        // Exactly the maximum length is forwarded.
        send_str("9876543210123456.");
        idle(25);
        chk_stream("t3_max_len", "9876543210123456 ");

        // Exactly the minimum length is forwarded.
        send_str("x007x");
        idle(10);
        chk_stream("t3_min_len", "007 ");

        // Idle cycles do not split a run.
        send_str("42");
        idle(5);
        send_str("1 ");
        idle(10);
        chk_stream("t4_idle", "421 ");

        // Reset while draining.
        send_str("98765 ");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5_mid_write", {31'b0, bus.write}, 32'd1);
        chk("t5_mid_data", {24'b0, bus.data_out}, 32'h38);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_write", {31'b0, bus.write}, 32'd0);
        chk("t5_rst_data", {24'b0, bus.data_out}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        out_q.delete();
        idle(5);
        chk("t5_post_write", {31'b0, bus.write}, 32'd0);
        send_str("111.");
        idle(10);
        chk_stream("t5_after", "111 ");

        // Cycle-exact latency and back-to-back output.
        send_str(t6);
        chk("t6_write_k", {31'b0, bus.write}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t6_write_%0d", i), {31'b0, bus.write}, 32'd1);
            chk($sformatf("t6_data_%0d", i), {24'b0, bus.data_out}, {24'b0, t6[i]});
        end
        @(posedge clk);
        #1;
        chk("t6_write_end", {31'b0, bus.write}, 32'd0);
        chk("t6_data_hold", {24'b0, bus.data_out}, 32'h20);
        out_q.delete();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
